// File: rtl/pixel_out_streamer.sv
// Pixel drain buffer: MEM-stage pixel stores go into a circular buffer and are streamed out
// over valid/ready, one frame of FRAME_LEN pixels per start. Option: PIXEL_SATURATE_EN.
//
// state    | meaning
// S_IDLE   | buffer accepts pixels, no output; start begins a frame
// S_STREAM | buffered pixels are presented to the sink until the frame's last is accepted
// S_DONE   | one-cycle done pulse, then back to S_IDLE
module pixel_out_streamer #(
    parameter int PIX_W     = 8,
    parameter int DEPTH     = 1024,
    parameter int FRAME_LEN = 304200
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [31:0]      wr_data_i,
    input  logic             start_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [PIX_W-1:0] m_data_o,
    output logic             m_last_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
    localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

    logic [PIX_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      occ_q;
    logic [CW-1:0]    pix_cnt_q, pix_cnt_d;
    state_t           state_q, state_d;
    logic             overflow_q;
    logic             push, pop;
    logic [PIX_W-1:0] pix_conv;

`ifdef PIXEL_SATURATE_EN
    localparam logic [31:0] PIX_MAX = 32'((64'd1 << PIX_W) - 64'd1);

    always_comb begin
        if (wr_data_i[31])
            pix_conv = '0;
        else if (wr_data_i > PIX_MAX)
            pix_conv = '1;
        else
            pix_conv = wr_data_i[PIX_W-1:0];
    end
`else
    logic unused_hi_bits;
    assign unused_hi_bits = ^wr_data_i[31:PIX_W];
    assign pix_conv       = wr_data_i[PIX_W-1:0];
`endif

    assign full_o     = (occ_q == OCC_FULL);
    assign empty_o    = (occ_q == '0);
    assign overflow_o = overflow_q;
    assign m_valid_o  = (state_q == S_STREAM) && !empty_o;
    assign m_last_o   = m_valid_o && (pix_cnt_q == LAST_IDX);
    assign m_data_o   = m_valid_o ? mem_q[rd_ptr_q] : '0;

    // full is the pre-edge value, so a write into a full buffer is dropped even if a pop frees a slot
    assign push = wr_en_i && !full_o;
    assign pop  = m_valid_o && m_ready_i;

    always_ff @(posedge clk_i) begin
        if (push)
            mem_q[wr_ptr_q] <= pix_conv;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
            pix_cnt_q  <= '0;
            state_q    <= S_IDLE;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)
                occ_q <= occ_q + 1'b1;
            else if (pop && !push)
                occ_q <= occ_q - 1'b1;
            if (wr_en_i && full_o)
                overflow_q <= 1'b1;
            pix_cnt_q <= pix_cnt_d;
            state_q   <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_STREAM;
                    pix_cnt_d = '0;
                end
            end
            S_STREAM: begin
                busy_o = 1'b1;
                // the counter stops at the last index instead of wrapping into the next frame
                if (pop) begin
                    if (m_last_o)
                        state_d = S_DONE;
                    else
                        pix_cnt_d = pix_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_pixel_out_streamer.sv
// Self-checking bench for pixel_out_streamer: directed sequences plus random traffic,
// compared every cycle against a queue-based frame model.
module tb_pixel_out_streamer;
    localparam int PIX_W     = 8;
    localparam int DEPTH     = 4;
    localparam int FRAME_LEN = 6;
    localparam longint PMAX  = (64'd1 << PIX_W) - 1;

    logic             clk;
    logic             rst_i, wr_en_i, start_i, m_ready_i;
    logic [31:0]      wr_data_i;
    logic             m_valid_o, m_last_o, full_o, empty_o, overflow_o, busy_o, done_o;
    logic [PIX_W-1:0] m_data_o;

    int n_vec = 0;
    int n_err = 0;

    int unsigned q[$];
    bit  strm, dn, ovf;
    int  sent;

    pixel_out_streamer #(.PIX_W(PIX_W), .DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
        .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
        .start_i(start_i), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .m_data_o(m_data_o), .m_last_o(m_last_o), .full_o(full_o), .empty_o(empty_o),
        .overflow_o(overflow_o), .busy_o(busy_o), .done_o(done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned conv(input logic [31:0] d);
`ifdef PIXEL_SATURATE_EN
        longint v;
        v = longint'($signed(d));
        if (v < 0) return 0;
        if (v > PMAX) return int'(PMAX);
        return int'(v);
`else
        return int'(longint'(d) % (PMAX + 1));
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        strm = 0;
        dn   = 0;
        ovf  = 0;
        sent = 0;
    endtask

    task automatic model_update();
        bit was_full, was_strm, was_dn, popped, last;
        if (rst_i) begin
            model_reset();
            return;
        end
        was_full = (q.size() == DEPTH);
        was_strm = strm;
        was_dn   = dn;
        popped   = was_strm && (q.size() > 0) && m_ready_i;
        last     = popped && (sent == FRAME_LEN - 1);
        dn = 0;
        if (popped) begin
            void'(q.pop_front());
            if (last) begin
                strm = 0;
                dn   = 1;
            end else begin
                sent++;
            end
        end
        if (!was_strm && !was_dn && start_i) begin
            strm = 1;
            sent = 0;
        end
        if (wr_en_i) begin
            if (was_full) ovf = 1;
            else q.push_back(conv(wr_data_i));
        end
    endtask

    task automatic check_outputs();
        bit ev;
        ev = strm && (q.size() > 0);
        check("m_valid",  32'(m_valid_o),  32'(ev));
        check("m_data",   32'(m_data_o),   ev ? q[0] : 32'd0);
        check("m_last",   32'(m_last_o),   32'(ev && (sent == FRAME_LEN - 1)));
        check("full",     32'(full_o),     32'(q.size() == DEPTH));
        check("empty",    32'(empty_o),    32'(q.size() == 0));
        check("overflow", 32'(overflow_o), 32'(ovf));
        check("busy",     32'(busy_o),     32'(strm));
        check("done",     32'(done_o),     32'(dn));
    endtask

    task automatic step(input bit r, input bit w, input logic [31:0] d, input bit s, input bit rd);
        @(negedge clk);
        check_outputs();
        rst_i     = r;
        wr_en_i   = w;
        wr_data_i = d;
        start_i   = s;
        m_ready_i = rd;
        @(posedge clk);
        model_update();
    endtask

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 255));
            1:       return 32'($urandom_range(256, 1000));
            2:       return -32'($urandom_range(1, 300));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int p_wr, p_rd;
        rst_i = 1'b1; wr_en_i = 1'b0; wr_data_i = '0; start_i = 1'b0; m_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        step(0, 0, 0, 0, 0);

        // basic frame of FRAME_LEN pixels, full drain
        for (int i = 1; i <= FRAME_LEN; i++) begin
            step(0, 1, 32'(i * 16), 0, 0);
            if (i == 4) step(0, 0, 0, 1, 1);
        end
        repeat (FRAME_LEN + 3) step(0, 0, 0, 0, 1);

        // overflow, backpressure hold, saturation values streamed mid-frame
        step(1, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) step(0, 1, 32'(i), 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        repeat (5) step(0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 1);
        step(0, 1, 32'd300, 0, 1);
        step(0, 1, -32'd7, 0, 1);
        step(0, 1, 32'd128, 0, 1);
        repeat (4) step(0, 0, 0, 1, 1);

        // reset mid-stream
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 32'(i + 5), 0, 0);
        step(0, 0, 0, 1, 1);
        repeat (2) step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0, 1);

        // random traffic with varying write/drain pressure
        for (int ph = 0; ph < 6; ph++) begin
            p_wr = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 50 : 90;
            p_rd = (ph < 3) ? 80 : 35;
            for (int c = 0; c < 400; c++) begin
                step(($urandom_range(0, 299) == 0),
                     ($urandom_range(0, 99) < p_wr),
                     rand_data(),
                     ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 99) < p_rd));
            end
        end
        step(0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
